// File: rtl/mouse_shot_pkg.sv
// Shared types and constants for the mouse shot path.
package mouse_shot_pkg;

  localparam int COORD_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COOLDOWN,
    EMPTY
  } shot_state_t;

endpackage

// File: rtl/shot_cooldown_timer.sv
// Loadable down-counter for the reload dead time; done flags the cycle the count expires.
module shot_cooldown_timer #(
  parameter int COOLDOWN_CYCLES = 6_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CW = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(COOLDOWN_CYCLES);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  // Asserted while the count holds its last value, so the FSM leaves on the edge that zeroes it.
  assign done = (count <= CW'(1));

endmodule

// File: rtl/mouse_shot_ctl.sv
// Shot controller: click edge detect, shot record latch with valid/ack, reload cooldown, ammo.
module mouse_shot_ctl
  import mouse_shot_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = 6_500_000,
  parameter int AMMO            = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COORD_W-1:0]         xpos,
  input  logic [COORD_W-1:0]         ypos,
  input  logic                       left,
  input  logic                       new_round,
  input  logic                       shot_ack,
  output logic                       shot_valid,
  output logic [COORD_W-1:0]         shot_x,
  output logic [COORD_W-1:0]         shot_y,
  output logic [$clog2(AMMO+1)-1:0]  ammo,
  output logic                       busy
);

  localparam int AW = $clog2(AMMO + 1);

  shot_state_t   state, state_nxt, exit_state;
  logic          left_d;
  logic          click;
  logic          latch;
  logic          timer_load;
  logic          timer_done;
  logic [AW-1:0] ammo_fill, ammo_nxt;

  shot_cooldown_timer #(
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .done (timer_done)
  );

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    click      = left & ~left_d;
    ammo_fill  = new_round ? AW'(AMMO) : ammo;
    ammo_nxt   = ammo_fill;
    exit_state = (ammo_fill != '0) ? IDLE : EMPTY;
    state_nxt  = state;
    latch      = 1'b0;
    timer_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (click && ammo_fill != '0) begin
          state_nxt = PENDING;
          latch     = 1'b1;
          ammo_nxt  = ammo_fill - AW'(1);
        end
      end
      PENDING: begin
        if (shot_ack) begin
          if (COOLDOWN_CYCLES == 0) begin
            state_nxt = exit_state;
          end else begin
            state_nxt  = COOLDOWN;
            timer_load = 1'b1;
          end
        end
      end
      COOLDOWN: begin
        if (timer_done) state_nxt = exit_state;
      end
      EMPTY: begin
        if (new_round) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // left_d resets high so a button already held at reset release is not seen as a click.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      left_d     <= 1'b1;
      shot_x     <= '0;
      shot_y     <= '0;
      ammo       <= AW'(AMMO);
      shot_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      left_d     <= left;
      ammo       <= ammo_nxt;
      shot_valid <= (state_nxt == PENDING);
      busy       <= (state_nxt != IDLE);
      if (latch) begin
        shot_x <= xpos;
        shot_y <= ypos;
      end
    end
  end

endmodule
